conv_relu_layer: RTL and testbench
==================================

Name: conv_relu_layer

Overview:
- Convolution stage directly upstream of the max-pooling stage.
- Reads an input feature map from the shared data RAM and weights/biases from a weight RAM.
- Computes a stride-1, unpadded multi-channel 2-D convolution with bias, ReLU and saturation.
- Writes each output pixel back to the data RAM. The pooling stage later reads that region with its unsigned compare, which is valid because every value written is non-negative.

Parameters:
memaddrbit, 14, width of all address/dimension buses
width, 16, signed fixed-point data/weight width
frac, 8, fractional bits of data and weights
accw, 40, signed accumulator width (at least 2*width+8)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
enable  input  1  start request, sampled only in IDLE
checkram  input  1  after the last pixel, go to CHECK instead of IDLE
dkr,dkc  input  memaddrbit  kernel rows/cols
dr,dc,di  input  memaddrbit  input rows/cols/channels
dr_out,dc_out,di_out  input  memaddrbit  output rows/cols/channels (dr_out=dr-dkr+1, dc_out=dc-dkc+1)
inaddr,outaddr  input  memaddrbit  data RAM base addresses
waddr,baddr  input  memaddrbit  weight RAM base addresses of weights and biases
memaddr  output  memaddrbit  registered data RAM address
data_in  input  width  data RAM read data
weight_addr  output  memaddrbit  registered weight RAM address
weight_in  input  width  weight RAM read data
conv_out  output  width  result; zero outside OUT
wea  output  1  data RAM write enable; high only in OUT
state  output  3  current FSM state
picture_finish  output  1  whole layer done

Behaviour:
- Reset: all outputs and registers are 0; state=IDLE. Reset mid-run aborts immediately and leaves no partial state.
- States: IDLE=0, BIAS=1, MAC=2, WB=3, OUT=4, CHECK=5.
- IDLE: enable -> BIAS. On leaving IDLE, clear picture_finish and pixel counters (io, or, oc).
- RAM latency contract: an address registered at edge E returns data sampled at edge E+2.
- BIAS, 3 cycles: cycle 0 registers weight_addr=baddr+io; end of cycle 2 latches the bias.
- MAC, N+2 cycles, N=di*dkr*dkc:
  - Element counters iterate ikc fastest, then ikr, then ii.
  - End of cycle m (0..N-1) registers memaddr=inaddr+ii*dr*dc+(or+ikr)*dc+oc+ikc and weight_addr=waddr+((io*di+ii)*dkr+ikr)*dkc+ikc.
  - End of cycle m+2 adds the signed product data_in*weight_in to acc; acc is cleared on entry to MAC.
- WB, 1 cycle:
  - result = (acc >>> frac) + sign-extended bias.
  - Negative -> 0; above 2^(width-1)-1 -> saturate to 2^(width-1)-1.
  - Register result; register memaddr=outaddr+io*dr_out*dc_out+or*dc_out+oc.
- OUT, 1 cycle: wea=1, conv_out=result.
  - Pixel order: oc fastest, then or, then io.
  - Not last pixel -> BIAS.
  - Last pixel -> set picture_finish, then go to CHECK if checkram else IDLE.
- Per-pixel period is exactly N+7 cycles. Total run length is di_out*dr_out*dc_out*(N+7).
- CHECK: terminal until reset. memaddr and weight_addr are 0; wea=0.
- picture_finish stays high in IDLE/CHECK until the next start.
- enable is ignored outside IDLE.
- Dimension sizes of 1 are legal (1x1 kernel, single channel, single pixel).
- Address arithmetic is modulo 2^memaddrbit.

Decomposition:
- Shared package: state encodings, accw derivation, saturation max constant.
- Sub-module conv_relu_sat: combinational shift, bias add, ReLU and saturation, parameterised by width/frac/accw.

Test Plan:
- 1x1 kernel, di=1, dr=dc=2, weight=256, bias=0, inputs 10,20,30,40 -> writes 10,20,30,40 to outaddr+0..3. wea pulses are 8 cycles apart; picture_finish is then set and the FSM returns to IDLE.
- dkr=dkc=3, di=2, dr=dc=4, all weights 256, all inputs 256, bias 256 -> four outputs of 4864 at outaddr+0..3, per-pixel period 25.
- Weight -256, inputs positive -> all outputs 0; wea is still asserted per pixel.
- 3x3 kernel, inputs 0x7FFF, weights 0x7FFF -> output 0x7FFF (saturation), no wraparound.
- checkram=1 on a 1-pixel run -> state goes to 5 and stays there for 100 cycles; enable is ignored.
- Assert rst during MAC of the second pixel, then restart -> all outputs are 0 during reset and the full run repeats from pixel 0 with correct results.

Source files
------------

// File: rtl/conv_relu_layer_pkg.sv
// conv_relu_layer_pkg: shared state encoding and arithmetic constants for the conv/ReLU layer
package conv_relu_layer_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BIAS  = 3'd1,
        MAC   = 3'd2,
        WB    = 3'd3,
        OUT   = 3'd4,
        CHECK = 3'd5
    } state_t;
    function automatic int acc_width(input int w);
        return 2 * w + 8;
    endfunction
    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction
endpackage

// File: rtl/conv_relu_sat.sv
// conv_relu_sat: rescale accumulator, add bias, clamp to [0, max positive]
module conv_relu_sat
    import conv_relu_layer_pkg::*;
#(
    parameter int width = 16,
    parameter int frac  = 8,
    parameter int accw  = acc_width(16)
) (
    input  logic [accw-1:0]  acc,
    input  logic [width-1:0] bias,
    output logic [width-1:0] res
);
    localparam logic signed [accw-1:0] MAX = accw'(sat_max(width));
    logic signed [accw-1:0] sh, bx, sum;
    assign sh  = $signed(acc) >>> frac;
    assign bx  = {{(accw - width){bias[width-1]}}, bias};
    assign sum = sh + bx;
    assign res = sum[accw-1] ? '0 : (sum > MAX ? MAX[width-1:0] : sum[width-1:0]);
endmodule

// File: rtl/conv_relu_layer.sv
// conv_relu_layer: stride-1 unpadded multi-channel convolution with bias, ReLU and saturation,
// streaming operands from the data/weight RAMs and writing each pixel back to the data RAM.
module conv_relu_layer
    import conv_relu_layer_pkg::*;
#(
    parameter int memaddrbit = 14,
    parameter int width      = 16,
    parameter int frac       = 8,
    parameter int accw       = acc_width(16)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  checkram,
    input  logic [memaddrbit-1:0] dkr,
    input  logic [memaddrbit-1:0] dkc,
    input  logic [memaddrbit-1:0] dr,
    input  logic [memaddrbit-1:0] dc,
    input  logic [memaddrbit-1:0] di,
    input  logic [memaddrbit-1:0] dr_out,
    input  logic [memaddrbit-1:0] dc_out,
    input  logic [memaddrbit-1:0] di_out,
    input  logic [memaddrbit-1:0] inaddr,
    input  logic [memaddrbit-1:0] outaddr,
    input  logic [memaddrbit-1:0] waddr,
    input  logic [memaddrbit-1:0] baddr,
    output logic [memaddrbit-1:0] memaddr,
    input  logic [width-1:0]      data_in,
    output logic [memaddrbit-1:0] weight_addr,
    input  logic [width-1:0]      weight_in,
    output logic [width-1:0]      conv_out,
    output logic                  wea,
    output logic [2:0]            state,
    output logic                  picture_finish
);
    localparam logic [memaddrbit-1:0] ONE = memaddrbit'(1);
    state_t st, st_nx;
    logic [1:0] bcnt, v;
    logic issued, last_k, last_px, kc_wrap, kr_wrap, oc_wrap, or_wrap;
    logic [memaddrbit-1:0] io, orow, ocol, ii, kr, kc;
    logic [accw-1:0] acc;
    logic [width-1:0] bias, result, sat_res;
    logic signed [2*width-1:0] dx, wx, prod;
    assign dx      = {{width{data_in[width-1]}}, data_in};
    assign wx      = {{width{weight_in[width-1]}}, weight_in};
    assign prod    = dx * wx;
    assign kc_wrap = kc == dkc - ONE;
    assign kr_wrap = kr == dkr - ONE;
    assign last_k  = kc_wrap && kr_wrap && ii == di - ONE;
    assign oc_wrap = ocol == dc_out - ONE;
    assign or_wrap = orow == dr_out - ONE;
    assign last_px = oc_wrap && or_wrap && io == di_out - ONE;
    assign wea      = st == OUT;
    assign conv_out = st == OUT ? result : '0;
    assign state    = st;
    conv_relu_sat #(.width(width), .frac(frac), .accw(accw)) u_sat (
        .acc (acc),
        .bias(bias),
        .res (sat_res)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= IDLE;
        else st <= st_nx;
    end
    // MAC ends once every element is issued and the last product (v[1]) is being summed
    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = enable ? BIAS : IDLE;
            BIAS:    st_nx = bcnt == 2'd2 ? MAC : BIAS;
            MAC:     st_nx = (issued && v == 2'b10) ? WB : MAC;
            WB:      st_nx = OUT;
            OUT:     st_nx = !last_px ? BIAS : (checkram ? CHECK : IDLE);
            default: st_nx = st;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {bcnt, v, issued, picture_finish} <= '0;
            {io, orow, ocol, ii, kr, kc} <= '0;
            {memaddr, weight_addr} <= '0;
            {acc, bias, result} <= '0;
        end else begin
            case (st)
                IDLE: if (enable) {picture_finish, io, orow, ocol} <= '0;
                BIAS: begin
                    bcnt <= bcnt == 2'd2 ? 2'd0 : bcnt + 2'd1;
                    if (bcnt == 2'd0) weight_addr <= baddr + io;
                    if (bcnt == 2'd2) {bias, acc, ii, kr, kc, issued, v} <= {weight_in, {accw{1'b0}}, {(3*memaddrbit+3){1'b0}}};
                end
                MAC: begin
                    v <= {v[0], !issued};
                    if (v[1]) acc <= acc + {{(accw - 2*width){prod[2*width-1]}}, prod};
                    if (!issued) begin
                        memaddr     <= inaddr + ii*dr*dc + (orow + kr)*dc + ocol + kc;
                        weight_addr <= waddr + ((io*di + ii)*dkr + kr)*dkc + kc;
                        kc     <= kc_wrap ? '0 : kc + ONE;
                        kr     <= kc_wrap ? (kr_wrap ? '0 : kr + ONE) : kr;
                        ii     <= (kc_wrap && kr_wrap) ? ii + ONE : ii;
                        issued <= last_k;
                    end
                end
                WB: begin
                    result  <= sat_res;
                    memaddr <= outaddr + io*dr_out*dc_out + orow*dc_out + ocol;
                end
                OUT: begin
                    ocol <= oc_wrap ? '0 : ocol + ONE;
                    orow <= oc_wrap ? (or_wrap ? '0 : orow + ONE) : orow;
                    io   <= (oc_wrap && or_wrap) ? io + ONE : io;
                    if (last_px) picture_finish <= 1'b1;
                    if (last_px && checkram) {memaddr, weight_addr} <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_relu_layer.sv
// tb_conv_relu_layer: directed runs with a write scoreboard checked by an independent monitor
module tb_conv_relu_layer;
    localparam int AW = 14, W = 16;
    logic clk = 0, rst = 0, enable = 0, checkram = 0;
    logic [AW-1:0] dkr = '0, dkc = '0, dr = '0, dc = '0, di = '0, dr_out = '0, dc_out = '0, di_out = '0;
    logic [AW-1:0] inaddr = '0, outaddr = '0, waddr = '0, baddr = '0;
    logic [AW-1:0] memaddr, weight_addr;
    logic [W-1:0] data_in, weight_in, conv_out;
    logic wea, picture_finish;
    logic [2:0] state;
    logic [W-1:0] dram [0:(1<<AW)-1];
    logic [W-1:0] wram [0:(1<<AW)-1];
    logic ld_en = 0, ld_w = 0;
    logic [AW-1:0] ld_a = '0;
    logic [W-1:0] ld_d = '0;
    typedef struct {int addr; int data; int gap;} exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0, cyc = 0, last_wr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // RAM models: one register stage so an address launched at edge E is sampled at E+2
    always @(posedge clk) begin
        if (wea) dram[memaddr] <= conv_out;
        if (ld_en && !ld_w) dram[ld_a] <= ld_d;
        if (ld_en && ld_w) wram[ld_a] <= ld_d;
        data_in   <= dram[memaddr];
        weight_in <= wram[weight_addr];
    end

    conv_relu_layer dut (
        .clk(clk), .rst(rst), .enable(enable), .checkram(checkram),
        .dkr(dkr), .dkc(dkc), .dr(dr), .dc(dc), .di(di),
        .dr_out(dr_out), .dc_out(dc_out), .di_out(di_out),
        .inaddr(inaddr), .outaddr(outaddr), .waddr(waddr), .baddr(baddr),
        .memaddr(memaddr), .data_in(data_in), .weight_addr(weight_addr), .weight_in(weight_in),
        .conv_out(conv_out), .wea(wea), .state(state), .picture_finish(picture_finish)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && wea) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write", memaddr, conv_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", int'(memaddr), e.addr);
                chk("wr_data", int'(conv_out), e.data);
                if (e.gap > 0) chk("wr_period", cyc - last_wr, e.gap);
            end
            last_wr = cyc;
        end
    end

    task automatic ld(input bit w, input int a, input int n, input int v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_en = 1; ld_w = w; ld_a = AW'(a + i); ld_d = W'(v);
        end
        @(negedge clk) ld_en = 0;
    endtask

    task automatic cfg(input int kr, input int kc, input int ch, input int r, input int c,
                       input int ia, input int oa, input int wa, input int ba);
        dkr = AW'(kr); dkc = AW'(kc); di = AW'(ch); dr = AW'(r); dc = AW'(c);
        dr_out = AW'(r - kr + 1); dc_out = AW'(c - kc + 1); di_out = AW'(1);
        inaddr = AW'(ia); outaddr = AW'(oa); waddr = AW'(wa); baddr = AW'(ba);
    endtask

    task automatic push(input int a, input int d, input int g);
        exp_t e;
        e.addr = a; e.data = d; e.gap = g;
        sb.push_back(e);
    endtask

    task automatic run(input int len, input int st_exp);
        int n = 0;
        @(negedge clk) enable = 1;
        @(posedge clk); #1 enable = 0;
        while (!picture_finish && n < 5000) begin @(posedge clk); #1; n++; end
        chk("run_length", n, len);
        chk("end_state", int'(state), st_exp);
        repeat (2) @(posedge clk);
        #1 chk("finish_held", int'(picture_finish), 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_memaddr"}, int'(memaddr), 0);
        chk({tag, "_weight_addr"}, int'(weight_addr), 0);
        chk({tag, "_conv_out"}, int'(conv_out), 0);
        chk({tag, "_wea_finish"}, int'({wea, picture_finish}), 0);
    endtask

    initial begin
        int n, bad;
        repeat (3) @(posedge clk);
        #1 chk_reset("reset");
        @(negedge clk) rst = 1;
        // 1x1 identity kernel over a 2x2 map
        ld(0, 100, 1, 10); ld(0, 101, 1, 20); ld(0, 102, 1, 30); ld(0, 103, 1, 40);
        ld(1, 10, 1, 256); ld(1, 20, 1, 0);
        cfg(1, 1, 1, 2, 2, 100, 200, 10, 20);
        push(200, 10, 0); push(201, 20, 8); push(202, 30, 8); push(203, 40, 8);
        run(32, 0);
        // 3x3x2 kernel of ones over ones, bias 1.0 -> 18+1 = 19.0
        ld(0, 1000, 32, 256); ld(1, 500, 18, 256); ld(1, 600, 1, 256);
        cfg(3, 3, 2, 4, 4, 1000, 2000, 500, 600);
        for (int i = 0; i < 4; i++) push(2000 + i, 4864, i == 0 ? 0 : 25);
        run(100, 0);
        // negative weights clamp to zero, writes still happen
        ld(0, 2100, 4, 16'hAAAA); ld(1, 700, 18, 16'hFF00);
        cfg(3, 3, 2, 4, 4, 1000, 2100, 700, 600);
        for (int i = 0; i < 4; i++) push(2100 + i, 0, i == 0 ? 0 : 25);
        run(100, 0);
        // saturation on a single pixel
        ld(0, 3000, 9, 16'h7FFF); ld(1, 800, 9, 16'h7FFF); ld(1, 900, 1, 0);
        cfg(3, 3, 1, 3, 3, 3000, 3050, 800, 900);
        push(3050, 32767, 0);
        run(16, 0);
        // checkram: terminal CHECK state ignoring enable
        checkram = 1;
        cfg(3, 3, 1, 3, 3, 3000, 3100, 800, 900);
        push(3100, 32767, 0);
        run(16, 5);
        enable = 1;
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (state != 3'd5 || wea || memaddr != '0 || weight_addr != '0) bad++;
        end
        enable = 0;
        chk("check_hold_bad_cycles", bad, 0);
        @(posedge clk); #1 rst = 0;
        #1 chk_reset("reset_from_check");
        repeat (2) @(posedge clk);
        #1 rst = 1;
        checkram = 0;
        // reset during MAC of pixel 1, then a clean rerun
        cfg(3, 3, 2, 4, 4, 1000, 2200, 500, 600);
        push(2200, 4864, 0);
        @(negedge clk) enable = 1;
        @(posedge clk); #1 enable = 0;
        n = 0;
        while (!wea && n < 200) begin @(posedge clk); #1; n++; end
        chk("midrst_first_write", int'(wea), 1);
        n = 0;
        while (state != 3'd2 && n < 200) begin @(posedge clk); #1; n++; end
        chk("midrst_in_mac", int'(state), 2);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1 chk_reset("midrst");
        repeat (2) @(posedge clk);
        #1 chk_reset("midrst_held");
        rst = 1;
        chk("midrst_sb_empty", sb.size(), 0);
        for (int i = 0; i < 4; i++) push(2200 + i, 4864, i == 0 ? 0 : 25);
        run(100, 0);
        repeat (5) @(posedge clk);
        #1 chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
